// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller.
// Covers the scoreboard state encoding and the reserved select and register values.
package hazard_forward_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MC_BUSY  = 2'd1,
      ST_MC_DRAIN = 2'd2
   } sb_state_e;

   localparam int SEL_REGFILE = 0;
   localparam int REG_X0      = 0;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_prio_sel.sv
// Priority bypass select for one EX source operand.
// The youngest writing stage that names the source wins. x0 never forwards.
module fwd_prio_sel
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2,
   parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
   input  logic [REG_AW-1:0]         src,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
   input  logic [NUM_FWD-1:0]        fwd_wr,
   output logic [SEL_W-1:0]          sel
);

   logic [REG_AW-1:0] rd_k;

   // Walk oldest to youngest so the lowest matching stage is the last one assigned.
   always_comb begin
      sel  = SEL_W'(SEL_REGFILE);
      rd_k = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         rd_k = fwd_rd[k*REG_AW +: REG_AW];
         if (fwd_wr[k] && (rd_k != REG_AW'(REG_X0)) && (rd_k == src)) begin
            sel = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select, load-use bubble and single-entry multicycle scoreboard
// for the in-order pipeline, plus a saturating count of stall cycles.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int  REG_AW  = 5,
   parameter int  NUM_SRC = 2,
   parameter int  NUM_FWD = 2,
   parameter int  CNT_W   = 32,
   localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] ID_EX_Rs,
   input  logic [NUM_FWD*REG_AW-1:0] Fwd_Rd,
   input  logic [NUM_FWD-1:0]        Fwd_Wr,
   input  logic [NUM_SRC*REG_AW-1:0] IF_ID_Rs,
   input  logic [NUM_SRC-1:0]        IF_ID_Rs_Use,
   input  logic [REG_AW-1:0]         IF_ID_Rd,
   input  logic                      IF_ID_Mc,
   input  logic [REG_AW-1:0]         ID_EX_Rd,
   input  logic                      ID_EX_MemRd,
   input  logic                      Mc_Start,
   input  logic                      Mc_Done,
   input  logic                      Cnt_Clr,
   output logic [NUM_SRC*SEL_W-1:0]  Forward_Sel,
   output logic                      Stall,
   output logic                      Flush_ID_EX,
   output logic                      Mc_Busy,
   output logic [CNT_W-1:0]          Stall_Cnt
);

   sb_state_e         state_q, state_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic hit_ld, hit_mc, load_use, sb_haz, mc_capture;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
         fwd_prio_sel #(
            .REG_AW  (REG_AW),
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
         ) u_sel (
            .src    (ID_EX_Rs[gi*REG_AW +: REG_AW]),
            .fwd_rd (Fwd_Rd),
            .fwd_wr (Fwd_Wr),
            .sel    (Forward_Sel[gi*SEL_W +: SEL_W])
         );
      end
   endgenerate

   // Busy and drain both block readers, writers and a second multicycle op.
   always_comb begin
      hit_ld = 1'b0;
      hit_mc = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (IF_ID_Rs_Use[i]) begin
            if (IF_ID_Rs[i*REG_AW +: REG_AW] == ID_EX_Rd) hit_ld = 1'b1;
            if (IF_ID_Rs[i*REG_AW +: REG_AW] == rd_q)     hit_mc = 1'b1;
         end
      end
      load_use = ID_EX_MemRd && (ID_EX_Rd != REG_AW'(REG_X0)) && hit_ld;
      sb_haz   = (state_q != ST_IDLE) && (hit_mc || (IF_ID_Rd == rd_q) || IF_ID_Mc);
   end

   assign Stall       = load_use | sb_haz;
   assign Flush_ID_EX = load_use | sb_haz;
   assign Mc_Busy     = (state_q != ST_IDLE);
   assign Stall_Cnt   = cnt_q;
   assign mc_capture  = Mc_Start && (ID_EX_Rd != REG_AW'(REG_X0));

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      case (state_q)
         ST_IDLE: begin
            if (mc_capture) begin
               state_d = ST_MC_BUSY;
               rd_d    = ID_EX_Rd;
            end
         end
         ST_MC_BUSY: begin
            if (Mc_Done) state_d = ST_MC_DRAIN;
         end
         ST_MC_DRAIN: begin
            if (mc_capture) begin
               state_d = ST_MC_BUSY;
               rd_d    = ID_EX_Rd;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (Cnt_Clr)                      cnt_d = '0;
      else if (Stall && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
